// File: rtl/uart_tx_hex_frame.sv
//==============================================================================
// Module  : uart_tx_hex_frame (with helper uart_tx_byte)
// Brief   : Latches an N-nibble word and prints it MSB nibble first as ASCII hex
//           over an 8N1 UART; define HEX_TX_CRLF_EN to append CR/LF per frame.
// Revision: 1.0
//==============================================================================
`default_nettype none

module uart_tx_byte #(
  parameter int CLK_FRE   = 100,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_i,
  input  logic       tx_data_valid_i,
  output logic       tx_data_ready_o,
  output logic       tx_pin_o
);
  localparam int CYCLE = (CLK_FRE * 1000000) / BAUD_RATE;
  localparam int CNT_W = $clog2(CYCLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             pin_q;
  logic             bit_end;

  assign bit_end         = (cnt_q == CNT_LAST);
  assign tx_data_ready_o = (state_q == S_IDLE);
  assign tx_pin_o        = pin_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pin_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          pin_q <= 1'b1;
          if (tx_data_valid_i) begin
            shift_q <= tx_data_i;
            pin_q   <= 1'b0;
            state_q <= S_START;
          end
        end
        default: begin
          cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
          if (bit_end) begin
            // Pin is registered, so the next bit value is loaded as the current one ends.
            case (state_q)
              S_START: begin
                pin_q   <= shift_q[0];
                shift_q <= shift_q >> 1;
                bit_q   <= '0;
                state_q <= S_DATA;
              end
              S_DATA: begin
                if (bit_q == 3'd7) begin
                  pin_q   <= 1'b1;
                  state_q <= S_STOP;
                end else begin
                  pin_q   <= shift_q[0];
                  shift_q <= shift_q >> 1;
                  bit_q   <= bit_q + 3'd1;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

module uart_tx_hex_frame #(
  parameter int NIBBLES   = 5,
  parameter int CLK_FRE   = 100,
  parameter int BAUD_RATE = 115200,
  parameter int HEX_LOWER = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 uart_tx
);
`ifdef HEX_TX_CRLF_EN
  localparam int N_BYTES = NIBBLES + 2;
`else
  localparam int N_BYTES = NIBBLES;
`endif
  localparam int IDX_W = $clog2(NIBBLES + 2) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [4*NIBBLES-1:0] shadow_q;
  logic                 tx_done_q;

  logic                 tx_data_valid;
  logic                 tx_data_ready;
  logic [3:0]           nib;
  logic [7:0]           tx_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 8'h30 + {4'h0, n};
    else           hex_ascii = ((HEX_LOWER != 0) ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction

  assign in_ready      = (state_q == S_IDLE);
  assign busy          = (state_q == S_SEND);
  assign tx_done       = tx_done_q;
  assign tx_data_valid = (state_q == S_SEND);

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) nib = shadow_q[4*(NIBBLES-1-i) +: 4];
    end
  end

  always_comb begin
    tx_byte = hex_ascii(nib);
`ifdef HEX_TX_CRLF_EN
    if (idx_q == IDX_W'(NIBBLES))          tx_byte = 8'h0D;
    else if (idx_q == IDX_W'(NIBBLES + 1)) tx_byte = 8'h0A;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shadow_q <= in_data;
            idx_q    <= '0;
            state_q  <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_data_ready) begin
            if (idx_q == IDX_LAST) begin
              idx_q     <= '0;
              state_q   <= S_IDLE;
              tx_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_FRE   (CLK_FRE),
    .BAUD_RATE (BAUD_RATE)
  ) u_uart_tx (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_data_i       (tx_byte),
    .tx_data_valid_i (tx_data_valid),
    .tx_data_ready_o (tx_data_ready),
    .tx_pin_o        (uart_tx)
  );
endmodule

`default_nettype wire

// File: tb/tb_uart_tx_hex_frame.sv
//==============================================================================
// Module  : tb_uart_tx_hex_frame
// Brief   : Scoreboard bench; UART line decoders pop expected ASCII bytes.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_hex_frame;
  // 100 MHz clock, 6.25 Mbaud -> 16 clocks per bit keeps frames short.
  localparam int CLK_FRE   = 100;
  localparam int BAUD_RATE = 6250000;
  localparam int BIT       = 16;
  localparam int FRAME_NS  = (10 * BIT + 1) * 10;
  localparam int LIMIT     = 20000;
`ifdef HEX_TX_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif
  localparam int NB1 = CRLF ? 7 : 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid1, in_ready1, busy1, tx_done1, line1;
  logic [19:0] in_data1;
  logic        in_valid2, in_ready2, busy2, tx_done2, line2;
  logic [7:0]  in_data2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  time        starts1[$];
  int n_checks = 0, n_pass = 0;
  int nbytes1 = 0, nbytes2 = 0;
  int rst_cnt = 0, done1_cnt = 0, done2_cnt = 0, width_err = 0;
  logic prev_done1 = 1'b0, prev_done2 = 1'b0;

  always #5 clk = ~clk;

  uart_tx_hex_frame #(
    .NIBBLES(5), .CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE), .HEX_LOWER(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .busy(busy1), .tx_done(tx_done1), .uart_tx(line1)
  );

  uart_tx_hex_frame #(
    .NIBBLES(2), .CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD_RATE), .HEX_LOWER(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .busy(busy2), .tx_done(tx_done2), .uart_tx(line2)
  );

  always @(posedge clk) if (!rst_n) rst_cnt <= rst_cnt + 1;

  always @(negedge clk) begin
    if (tx_done1) done1_cnt <= done1_cnt + 1;
    if (tx_done2) done2_cnt <= done2_cnt + 1;
    if ((tx_done1 && prev_done1) || (tx_done2 && prev_done2)) width_err <= width_err + 1;
    prev_done1 <= tx_done1;
    prev_done2 <= tx_done2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input int w, input logic [7:0] b);
    if (w == 0) q1.push_back(b);
    else        q2.push_back(b);
  endtask

  task automatic push_term(input int w);
    if (CRLF) begin
      push(w, 8'h0D);
      push(w, 8'h0A);
    end
  endtask

  function automatic logic line_of(input int w);
    return (w == 0) ? line1 : line2;
  endfunction

  task automatic mon(input int w);
    logic [7:0] b, e;
    logic       start_ok, stop_ok;
    int         r0, qs;
    if (w == 0) @(negedge line1);
    else        @(negedge line2);
    r0 = rst_cnt;
    if (w == 0) starts1.push_back($time);
    repeat (BIT / 2) @(posedge clk);
    start_ok = ~line_of(w);
    for (int k = 0; k < 8; k++) begin
      repeat (BIT) @(posedge clk);
      b[k] = line_of(w);
    end
    repeat (BIT) @(posedge clk);
    stop_ok = line_of(w);
    if (rst_cnt == r0) begin
      qs = (w == 0) ? q1.size() : q2.size();
      if (qs == 0) begin
        n_checks++;
        $display("FAIL line%0d byte: got %0h, no byte expected", w, b);
      end else begin
        e = (w == 0) ? q1.pop_front() : q2.pop_front();
        check($sformatf("line%0d byte", w), {22'd0, start_ok, stop_ok, b}, {22'd0, 2'b11, e});
      end
      if (w == 0) nbytes1++;
      else        nbytes2++;
    end
  endtask

  initial forever mon(0);
  initial forever mon(1);

  // Called right after a negedge; returns #1 after the accepting posedge.
  task automatic send(input int w, input logic [19:0] d, input bit keep);
    bit rdy;
    if (w == 0) begin in_data1 = d;      in_valid1 = 1'b1; end
    else        begin in_data2 = d[7:0]; in_valid2 = 1'b1; end
    rdy = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      rdy = (w == 0) ? in_ready1 : in_ready2;
      if (rdy) break;
      @(negedge clk);
    end
    check("accept in_ready", rdy, 1);
    @(posedge clk);
    #1;
    if (!keep) begin
      if (w == 0) in_valid1 = 1'b0;
      else        in_valid2 = 1'b0;
    end
  endtask

  task automatic wait_done(input int w, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < LIMIT && !seen; i++) begin
      @(negedge clk);
      seen = (w == 0) ? tx_done1 : tx_done2;
    end
  endtask

  task automatic drain(input int w);
    for (int i = 0; i < LIMIT; i++) begin
      if (((w == 0) ? q1.size() : q2.size()) == 0) break;
      @(negedge clk);
    end
    repeat (2 * BIT) @(negedge clk);
    check($sformatf("drain q%0d", w), (w == 0) ? q1.size() : q2.size(), 0);
  endtask

  initial begin
    bit seen;
    int bad, base_s, d0, n0;
    rst_n = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0;
    in_valid2 = 1'b0; in_data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", in_ready1, 1);
    check("reset busy", busy1, 0);
    check("reset tx_done", tx_done1, 0);
    check("reset line", line1, 1);
    check("reset dut2 in_ready/line", {in_ready2, line2, busy2}, 3'b110);
    rst_n = 1'b1;

    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (line1 !== 1'b1 || busy1 !== 1'b0 || tx_done1 !== 1'b0) bad++;
    end
    check("idle quiet", bad, 0);

    // A3F09 -> "A3F09"
    push(0, 8'h41); push(0, 8'h33); push(0, 8'h46); push(0, 8'h30); push(0, 8'h39);
    push_term(0);
    base_s = starts1.size();
    d0 = done1_cnt;
    send(0, 20'hA3F09, 1'b0);
    wait_done(0, seen);
    check("A3F09 tx_done", seen, 1);
    check("A3F09 bytes started at tx_done", starts1.size() - base_s, NB1);
    @(negedge clk);
    check("A3F09 tx_done one cycle", tx_done1, 0);
    check("A3F09 busy after", busy1, 0);
    drain(0);
    check("A3F09 tx_done count", done1_cnt - d0, 1);

    // Back-to-back 12345 / 6789A with in_valid held
    push(0, 8'h31); push(0, 8'h32); push(0, 8'h33); push(0, 8'h34); push(0, 8'h35);
    push_term(0);
    push(0, 8'h36); push(0, 8'h37); push(0, 8'h38); push(0, 8'h39); push(0, 8'h41);
    push_term(0);
    base_s = starts1.size();
    send(0, 20'h12345, 1'b1);
    in_data1 = 20'h6789A;
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < LIMIT && !seen; i++) begin
      @(negedge clk);
      if (tx_done1) seen = 1'b1;
      else if (in_ready1) bad++;
    end
    check("b2b first tx_done", seen, 1);
    check("b2b in_ready low in frame", bad, 0);
    check("b2b in_ready in tx_done cycle", in_ready1, 1);
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    check("b2b second frame busy", busy1, 1);
    wait_done(0, seen);
    check("b2b second tx_done", seen, 1);
    drain(0);
    check("b2b start count", starts1.size() - base_s, 2 * NB1);
    if (starts1.size() >= base_s + NB1 + 1) begin
      check("b2b spacing in frame", 32'(starts1[base_s+1] - starts1[base_s]), FRAME_NS);
      check("b2b spacing across frames", 32'(starts1[base_s+NB1] - starts1[base_s+NB1-1]), FRAME_NS);
    end

    // Reset in the middle of FFFFF
    push(0, 8'h46); push(0, 8'h46);
    d0 = done1_cnt;
    n0 = nbytes1;
    send(0, 20'hFFFFF, 1'b0);
    for (int i = 0; i < LIMIT && nbytes1 < n0 + 2; i++) @(negedge clk);
    check("rst two bytes out", nbytes1 - n0, 2);
    repeat (5 * BIT) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst line high", line1, 1);
    check("rst busy/in_ready", {busy1, in_ready1}, 2'b01);
    repeat (20 * BIT) @(negedge clk);
    check("rst no tx_done", done1_cnt - d0, 0);
    check("rst queue empty", q1.size(), 0);

    push(0, 8'h30); push(0, 8'h30); push(0, 8'h30); push(0, 8'h30); push(0, 8'h31);
    push_term(0);
    d0 = done1_cnt;
    send(0, 20'h00001, 1'b0);
    wait_done(0, seen);
    check("00001 tx_done", seen, 1);
    drain(0);
    check("00001 tx_done count", done1_cnt - d0, 1);

    // Lowercase 2-nibble instance; input changes during SEND are ignored
    push(1, 8'h61); push(1, 8'h62);
    push_term(1);
    d0 = done2_cnt;
    send(1, 20'h000AB, 1'b0);
    in_data2 = 8'h00;
    wait_done(1, seen);
    check("AB tx_done", seen, 1);
    drain(1);
    check("AB tx_done count", done2_cnt - d0, 1);

    check("tx_done pulse width", width_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
